// File: rtl/multiword_addsub_seq_pkg.sv
// Shared encodings for the multi-word add/subtract controller.
package multiword_addsub_seq_pkg;

   localparam int NIBBLE_W = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // One nibble's worth of adder-subtracter output.
   typedef struct packed {
      logic                cout;
      logic [NIBBLE_W-1:0] s;
   } nib_res_t;

endpackage

// File: rtl/multiword_addsub_seq_adder.sv
// 4-bit adder-subtracter: y is inverted by cin before the add, so
// cin=1 turns x + y + 1 into x - y (two's complement).
module Adder_subtracter_4Bit
   import multiword_addsub_seq_pkg::*;
(
   input  logic [NIBBLE_W-1:0] x_i,
   input  logic [NIBBLE_W-1:0] y_i,
   input  logic                cin_i,
   output logic [NIBBLE_W-1:0] s_o,
   output logic                cout_o
);

   logic [NIBBLE_W:0] sum;

   // Ripple sum of x, conditionally inverted y and carry-in.
   always_comb begin
      sum    = {1'b0, x_i} + {1'b0, y_i ^ {NIBBLE_W{cin_i}}} + {{NIBBLE_W{1'b0}}, cin_i};
      s_o    = sum[NIBBLE_W-1:0];
      cout_o = sum[NIBBLE_W];
   end

endmodule

// File: rtl/multiword_addsub_seq.sv
// Sequential multi-word add/subtract: walks the operands one nibble per
// clock through a single 4-bit adder-subtracter, chaining the carry.
module multiword_addsub_seq
   import multiword_addsub_seq_pkg::*;
#(
   parameter int NIBBLES = 4,
   localparam int W      = NIBBLE_W * NIBBLES,
   localparam int KW     = $clog2(NIBBLES)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic         op_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [W-1:0] result_o,
   output logic         carry_out_o,
   output logic         overflow_o
);

   state_e state_q, state_d;

   logic [NIBBLES-1:0][NIBBLE_W-1:0] a_q, a_d;
   logic [NIBBLES-1:0][NIBBLE_W-1:0] b_q, b_d;
   logic [NIBBLES-1:0][NIBBLE_W-1:0] result_q, result_d;
   logic                             op_q, op_d;
   logic [KW-1:0]                    k_q, k_d;
   logic                             c_q, c_d;
   logic                             cout_q, cout_d;
   logic                             ovf_q, ovf_d;

   logic [NIBBLE_W-1:0] a_nib, b_nib, y_nib;
   logic                last_nib;
   nib_res_t            add;

   // Nibble mux: select slice k of the latched operands.
   always_comb begin
      a_nib    = a_q[k_q];
      b_nib    = b_q[k_q];
      // The adder XORs y with cin again, so it effectively sees b ^ {op}.
      y_nib    = b_nib ^ {NIBBLE_W{op_q ^ c_q}};
      last_nib = (k_q == KW'(NIBBLES-1));
   end

   Adder_subtracter_4Bit u_addsub (
      .x_i    (a_nib),
      .y_i    (y_nib),
      .cin_i  (c_q),
      .s_o    (add.s),
      .cout_o (add.cout)
   );

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state: DONE always falls back to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_i) state_d = ST_RUN;
         ST_RUN:  if (last_nib) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy_o = (state_q == ST_RUN) || (state_q == ST_DONE);
      done_o = (state_q == ST_DONE);
   end

   // Datapath next-state: operands are latched only on an accepted start.
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      k_d      = k_q;
      c_d      = c_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               a_d  = a_i;
               b_d  = b_i;
               op_d = op_i;
               k_d  = '0;
               c_d  = op_i;
            end
         end
         ST_RUN: begin
            result_d[k_q] = add.s;
            c_d           = add.cout;
            if (last_nib) begin
               cout_d = add.cout;
               // Overflow: operands of equal effective sign, result sign differs.
               ovf_d  = (a_nib[NIBBLE_W-1] == (b_nib[NIBBLE_W-1] ^ op_q)) &&
                        (add.s[NIBBLE_W-1] != a_nib[NIBBLE_W-1]);
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= OP_ADD;
         k_q      <= '0;
         c_q      <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         k_q      <= k_d;
         c_q      <= c_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign result_o    = result_q;
   assign carry_out_o = cout_q;
   assign overflow_o  = ovf_q;

endmodule
